// File: rtl/if_stall_controller_if.sv
// if_stall_controller_if: bus between the hazard/branch/memory sources and the
// fetch-stage stall controller.
// Optional feature macro: STALL_PERF_CNT_EN adds Stall_Count and CNT_WIDTH.
interface if_stall_controller_if #(
   parameter int unsigned WORD_WIDTH = 32
`ifdef STALL_PERF_CNT_EN
   ,
   parameter int unsigned CNT_WIDTH  = 32
`endif
);

   logic                  Hazard;
   logic                  Branch_Taken;
   logic [WORD_WIDTH-1:0] Branch_Address;
   logic                  Mem_Req;
   logic                  Mem_Ready;
   logic                  Freeze_IF;
   logic                  Freeze_Pipe;
   logic                  Flush;
   logic                  Bubble;
   logic                  Redirect;
   logic [WORD_WIDTH-1:0] Redirect_Address;
`ifdef STALL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0]  Stall_Count;
`endif

   // Event sources: hazard unit, branch resolution and memory stage.
   modport master (
      output Hazard, Branch_Taken, Branch_Address, Mem_Req, Mem_Ready,
      input  Freeze_IF, Freeze_Pipe, Flush, Bubble, Redirect, Redirect_Address
`ifdef STALL_PERF_CNT_EN
      ,
      input  Stall_Count
`endif
   );

   // Stall controller.
   modport slave (
      input  Hazard, Branch_Taken, Branch_Address, Mem_Req, Mem_Ready,
      output Freeze_IF, Freeze_Pipe, Flush, Bubble, Redirect, Redirect_Address
`ifdef STALL_PERF_CNT_EN
      ,
      output Stall_Count
`endif
   );

endinterface

// File: rtl/if_stall_controller.sv
// if_stall_controller: sequences fetch freeze, pipeline freeze, flush, bubble
// and PC redirect. Arbitrates memory stalls over branches over hazards, and
// holds a branch that resolves while memory is stalled until the stall ends.
// Outputs are combinational from state and inputs; all state is registered.
// Optional feature macro: STALL_PERF_CNT_EN adds a saturating Freeze_IF cycle
// counter on Stall_Count.
module if_stall_controller #(
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned FLUSH_DEPTH = 1
`ifdef STALL_PERF_CNT_EN
   ,
   parameter int unsigned CNT_WIDTH   = 32
`endif
) (
   input logic                  clk,
   input logic                  rst,
   if_stall_controller_if.slave bus
);

   typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

   // Remaining flush cycles after the redirect cycle itself.
   localparam logic [2:0] FlushLoad  = 3'(FLUSH_DEPTH - 1);
   localparam bit         MultiFlush = (FLUSH_DEPTH > 1);

   state_e                state_q, state_d;
   logic                  pend_br_q, pend_br_d;
   logic [WORD_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [2:0]            flush_cnt_q, flush_cnt_d;

   logic                  mem_stall;
   logic                  start_redirect;
   logic [WORD_WIDTH-1:0] redirect_target;
   logic                  freeze_if, freeze_pipe, flush, bubble, redirect;
   logic [WORD_WIDTH-1:0] redirect_addr;

   assign mem_stall = bus.Mem_Req & ~bus.Mem_Ready;

   // Next-state and output decode; reset forces every output low.
   always_comb begin
      state_d         = state_q;
      pend_br_d       = pend_br_q;
      pend_addr_d     = pend_addr_q;
      flush_cnt_d     = flush_cnt_q;
      start_redirect  = 1'b0;
      redirect_target = '0;
      freeze_if       = 1'b0;
      freeze_pipe     = 1'b0;
      flush           = 1'b0;
      bubble          = 1'b0;
      redirect        = 1'b0;
      redirect_addr   = '0;

      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               freeze_if   = 1'b1;
               freeze_pipe = 1'b1;
               state_d     = StMemWait;
               if (bus.Branch_Taken) begin
                  pend_br_d   = 1'b1;
                  pend_addr_d = bus.Branch_Address;
               end
            end else if (bus.Branch_Taken) begin
               start_redirect  = 1'b1;
               redirect_target = bus.Branch_Address;
            end else if (bus.Hazard) begin
               freeze_if = 1'b1;
               bubble    = 1'b1;
            end
         end

         StMemWait: begin
            if (mem_stall) begin
               freeze_if   = 1'b1;
               freeze_pipe = 1'b1;
               // First branch seen during the stall wins.
               if (bus.Branch_Taken && !pend_br_q) begin
                  pend_br_d   = 1'b1;
                  pend_addr_d = bus.Branch_Address;
               end
            end else begin
               state_d = StRun;
               if (pend_br_q) begin
                  pend_br_d       = 1'b0;
                  start_redirect  = 1'b1;
                  redirect_target = pend_addr_q;
               end else if (bus.Branch_Taken) begin
                  start_redirect  = 1'b1;
                  redirect_target = bus.Branch_Address;
               end else if (bus.Hazard) begin
                  freeze_if = 1'b1;
                  bubble    = 1'b1;
               end
            end
         end

         StFlush: begin
            // Branches here are wrong-path and hazards are moot: ignore both.
            flush = 1'b1;
            if (mem_stall) begin
               freeze_if   = 1'b1;
               freeze_pipe = 1'b1;
            end else if (flush_cnt_q == 3'd1) begin
               flush_cnt_d = 3'd0;
               state_d     = StRun;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end

         default: state_d = StRun;
      endcase

      if (start_redirect) begin
         redirect      = 1'b1;
         redirect_addr = redirect_target;
         flush         = 1'b1;
         if (MultiFlush) begin
            state_d     = StFlush;
            flush_cnt_d = FlushLoad;
         end
      end

      if (rst) begin
         freeze_if     = 1'b0;
         freeze_pipe   = 1'b0;
         flush         = 1'b0;
         bubble        = 1'b0;
         redirect      = 1'b0;
         redirect_addr = '0;
      end
   end

   // State registers; reset drops any pending branch and flush in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         pend_br_q   <= 1'b0;
         pend_addr_q <= '0;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         pend_br_q   <= pend_br_d;
         pend_addr_q <= pend_addr_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.Freeze_IF        = freeze_if;
   assign bus.Freeze_Pipe      = freeze_pipe;
   assign bus.Flush            = flush;
   assign bus.Bubble           = bubble;
   assign bus.Redirect         = redirect;
   assign bus.Redirect_Address = redirect_addr;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;

   // Count fetch-freeze cycles, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (freeze_if && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign bus.Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stall_controller.sv
// tb_if_stall_controller: directed bench for if_stall_controller. Instance
// dut_a uses FLUSH_DEPTH=1, dut_b uses FLUSH_DEPTH=3. Expected outputs are
// queued when a step is driven and popped when the DUT outputs are sampled.
// With STALL_PERF_CNT_EN defined, dut_a uses CNT_WIDTH=4 and its Stall_Count
// is checked against a saturating model every cycle.
module tb_if_stall_controller;

   logic clk;
   logic rst;
   int   sel;
   int   total;
   int   passed;
   int   failed;

   logic [36:0] exp_q[$];
   string       tag_q[$];
`ifdef STALL_PERF_CNT_EN
   logic [3:0]  exp_cnt;
`endif

`ifdef STALL_PERF_CNT_EN
   if_stall_controller_if #(.WORD_WIDTH(32), .CNT_WIDTH(4)) a_if ();
`else
   if_stall_controller_if #(.WORD_WIDTH(32)) a_if ();
`endif
   if_stall_controller_if #(.WORD_WIDTH(32)) b_if ();

`ifdef STALL_PERF_CNT_EN
   if_stall_controller #(.WORD_WIDTH(32), .FLUSH_DEPTH(1), .CNT_WIDTH(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );
`else
   if_stall_controller #(.WORD_WIDTH(32), .FLUSH_DEPTH(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );
`endif

   if_stall_controller #(.WORD_WIDTH(32), .FLUSH_DEPTH(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack expected {Freeze_IF, Freeze_Pipe, Flush, Bubble, Redirect, Redirect_Address}.
   function automatic logic [36:0] e(input logic fi, input logic fp, input logic fl,
                                     input logic bb, input logic rd, input logic [31:0] ra);
      return {fi, fp, fl, bb, rd, ra};
   endfunction

   task automatic compare(input logic r);
      logic [36:0] got;
      logic [36:0] want;
      string       t;
      got = (sel == 0) ?
            {a_if.Freeze_IF, a_if.Freeze_Pipe, a_if.Flush, a_if.Bubble, a_if.Redirect,
             a_if.Redirect_Address} :
            {b_if.Freeze_IF, b_if.Freeze_Pipe, b_if.Flush, b_if.Bubble, b_if.Redirect,
             b_if.Redirect_Address};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      total++;
      assert (got === want) passed++;
      else begin
         failed++;
         $error("FAIL %s: fi/fp/fl/bb/rd/addr got %h required %h", t, got, want);
      end
`ifdef STALL_PERF_CNT_EN
      total++;
      assert (a_if.Stall_Count === exp_cnt) passed++;
      else begin
         failed++;
         $error("FAIL %s_cnt: Stall_Count got %0d required %0d", t, a_if.Stall_Count, exp_cnt);
      end
      if (r) exp_cnt = 4'd0;
      else if (sel == 0 && want[36] && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
`endif
   endtask

   task automatic step(input string tag, input logic r, input logic h, input logic bt,
                       input logic [31:0] ba, input logic mq, input logic mr,
                       input logic [36:0] ex);
      rst = r;
      a_if.Hazard = 1'b0; a_if.Branch_Taken = 1'b0; a_if.Branch_Address = '0;
      a_if.Mem_Req = 1'b0; a_if.Mem_Ready = 1'b0;
      b_if.Hazard = 1'b0; b_if.Branch_Taken = 1'b0; b_if.Branch_Address = '0;
      b_if.Mem_Req = 1'b0; b_if.Mem_Ready = 1'b0;
      if (sel == 0) begin
         a_if.Hazard = h; a_if.Branch_Taken = bt; a_if.Branch_Address = ba;
         a_if.Mem_Req = mq; a_if.Mem_Ready = mr;
      end else begin
         b_if.Hazard = h; b_if.Branch_Taken = bt; b_if.Branch_Address = ba;
         b_if.Mem_Req = mq; b_if.Mem_Ready = mr;
      end
      exp_q.push_back(ex);
      tag_q.push_back(tag);
      @(negedge clk);
      compare(r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [36:0] z;
      logic [36:0] stall;
      total  = 0;
      passed = 0;
      failed = 0;
      sel    = 0;
`ifdef STALL_PERF_CNT_EN
      exp_cnt = 4'd0;
`endif
      z     = e(0, 0, 0, 0, 0, 32'h0);
      stall = e(1, 1, 0, 0, 0, 32'h0);

      // Reset gates every output even with events present.
      step("rst_outputs", 1, 1, 1, 32'h44, 0, 0, z);
      step("rst_stall",   1, 0, 0, 32'h0, 1, 0, z);
      step("idle",        0, 0, 0, 32'h0, 0, 0, z);

      // Load-use hazard for one cycle.
      step("hazard",      0, 1, 0, 32'h0, 0, 0, e(1, 0, 0, 1, 0, 32'h0));
      step("hazard_off",  0, 0, 0, 32'h0, 0, 0, z);

      // Taken branch, single-cycle flush.
      step("br_40",       0, 0, 1, 32'h40, 0, 0, e(0, 0, 1, 0, 1, 32'h40));
      step("br_40_after", 0, 0, 0, 32'h0, 0, 0, z);

      // Branch beats hazard.
      step("br_hz",       0, 1, 1, 32'h44, 0, 0, e(0, 0, 1, 0, 1, 32'h44));
      step("br_hz_after", 0, 0, 0, 32'h0, 0, 0, z);

      // Memory stall with a branch held until the access completes.
      step("mw_c1",       0, 0, 0, 32'h0, 1, 0, stall);
      step("mw_c2_br80",  0, 0, 1, 32'h80, 1, 0, stall);
      step("mw_c3_br90",  0, 1, 1, 32'h90, 1, 0, stall);
      step("mw_c4_ready", 0, 0, 0, 32'h0, 1, 1, e(0, 0, 1, 0, 1, 32'h80));
      step("mw_after",    0, 0, 0, 32'h0, 0, 0, z);

      // Ready without request is ignored.
      step("rdy_no_req",  0, 0, 0, 32'h0, 0, 1, z);

      // Stall and branch together in RUN; stall wins, branch held.
      step("st_br_c1",    0, 0, 1, 32'h100, 1, 0, stall);
      step("st_br_ready", 0, 0, 0, 32'h0, 1, 1, e(0, 0, 1, 0, 1, 32'h100));

      // Hazard on the completing cycle with no pending branch.
      step("mw_hz_c1",    0, 0, 0, 32'h0, 1, 0, stall);
      step("mw_hz_ready", 0, 1, 0, 32'h0, 1, 1, e(1, 0, 0, 1, 0, 32'h0));
      step("mw_hz_after", 0, 0, 0, 32'h0, 0, 0, z);

      // Reset during a stall with a pending branch drops the branch.
      step("rp_stall",    0, 0, 1, 32'hc0, 1, 0, stall);
      step("rp_rst",      1, 0, 0, 32'h0, 1, 1, z);
      step("rp_ready",    0, 0, 0, 32'h0, 1, 1, z);
      step("rp_stall2",   0, 0, 0, 32'h0, 1, 0, stall);
      step("rp_ready2",   0, 0, 0, 32'h0, 1, 1, z);

      // Long stall; drives the counter past saturation when present.
      for (int i = 0; i < 20; i++) begin
         step("long_stall", 0, 0, 0, 32'h0, 1, 0, stall);
      end
      step("long_ready",  0, 0, 0, 32'h0, 1, 1, z);

      // Three-cycle flush on dut_b; wrong-path branch and hazard ignored.
      sel = 1;
      step("d3_idle",     0, 0, 0, 32'h0, 0, 0, z);
      step("d3_br_10",    0, 0, 1, 32'h10, 0, 0, e(0, 0, 1, 0, 1, 32'h10));
      step("d3_fl2",      0, 1, 1, 32'h20, 0, 0, e(0, 0, 1, 0, 0, 32'h0));
      step("d3_fl3",      0, 0, 0, 32'h0, 0, 0, e(0, 0, 1, 0, 0, 32'h0));
      step("d3_done",     0, 0, 0, 32'h0, 0, 0, z);

      // Memory stall inside the flush stretches it by the stall length.
      step("d3s_br",      0, 0, 1, 32'h10, 0, 0, e(0, 0, 1, 0, 1, 32'h10));
      step("d3s_st1",     0, 0, 0, 32'h0, 1, 0, e(1, 1, 1, 0, 0, 32'h0));
      step("d3s_st2",     0, 0, 0, 32'h0, 1, 0, e(1, 1, 1, 0, 0, 32'h0));
      step("d3s_rdy",     0, 0, 0, 32'h0, 1, 1, e(0, 0, 1, 0, 0, 32'h0));
      step("d3s_fl",      0, 0, 0, 32'h0, 0, 0, e(0, 0, 1, 0, 0, 32'h0));
      step("d3s_done",    0, 0, 0, 32'h0, 0, 0, z);

      // Reset mid-flush abandons the flush.
      step("d3r_br",      0, 0, 1, 32'h10, 0, 0, e(0, 0, 1, 0, 1, 32'h10));
      step("d3r_rst",     1, 0, 0, 32'h0, 0, 0, z);
      step("d3r_after",   0, 0, 0, 32'h0, 0, 0, z);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
